// File: rtl/text_buffer_writer_if.sv
// Byte-stream handshake into the text buffer writer.
// Latency: n/a (wires only).
// Backpressure: producer holds in_data/in_valid until it sees in_ready high.
//
// Signals:
//   in_data  - character or control byte from the producer
//   in_valid - in_data is meaningful this cycle
//   in_ready - consumer can take a byte this cycle
interface text_buffer_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/text_buffer_writer.sv
// Character-array writer: turns a byte stream into a ROWS x COLS text screen.
// Latency: cell and cursor updates appear 1 cycle after the accepting clk edge.
// Backpressure: in_ready low for N cycles on clear and N-COLS cycles on scroll.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   in_if      - byte stream handshake (slave side)
//   chars      - screen contents, chars[0] top-left, row-major
//   cursor     - cell that the next printable byte lands in
//   busy       - clear or scroll sweep in progress
module text_buffer_writer #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 2,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  text_buffer_writer_if.slave            in_if,
  output logic [7:0]                     chars [ROWS*COLS-1:0],
  output logic [$clog2(ROWS*COLS)-1:0]   cursor,
  output logic                           busy
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);

  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [AW-1:0] LAST_CELL  = AW'(N - 1);
  localparam logic [AW-1:0] LAST_ROW   = AW'(N - COLS);
  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [AW-1:0] SCROLL_END = AW'(N - COLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;

  // Start of the cursor's row and of the row below it.
  logic [AW-1:0] row_base;
  logic [AW-1:0] next_row_base;
  logic          printable;
  logic [AW-1:0] scroll_src;

  always_comb begin
    row_base      = AW'((int'(cursor) / COLS) * COLS);
    next_row_base = row_base + COLS_A;
    printable     = (in_if.in_data >= 8'h20) && (in_if.in_data <= 8'h7E);
    scroll_src    = idx + COLS_A;
  end

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cursor <= '0;
      idx    <= '0;
      for (int i = 0; i < N; i++) begin
        chars[i] <= BLANK;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_if.in_valid) begin
            if (printable) begin
              chars[cursor] <= in_if.in_data;
              // Writing the bottom-right cell pushes the whole screen up;
              // the cursor is repositioned when the sweep finishes.
              if (cursor == LAST_CELL) begin
                state <= SCROLL;
                idx   <= '0;
              end else begin
                cursor <= cursor + ONE;
              end
            end else begin
              case (in_if.in_data)
                CH_LF: begin
                  if (cursor < LAST_ROW) begin
                    cursor <= next_row_base;
                  end else begin
                    state <= SCROLL;
                    idx   <= '0;
                  end
                end
                CH_CR: begin
                  cursor <= row_base;
                end
                CH_BS: begin
                  // Backspace may wrap to the end of the previous row.
                  if (cursor != '0) begin
                    cursor               <= cursor - ONE;
                    chars[cursor - ONE]  <= BLANK;
                  end
                end
                CH_FF: begin
                  state  <= CLEAR;
                  idx    <= '0;
                  cursor <= '0;
                end
                default: begin
                  // Unknown control byte: consumed and dropped.
                end
              endcase
            end
          end
        end

        CLEAR: begin
          chars[idx] <= BLANK;
          if (idx == LAST_CELL) begin
            state <= IDLE;
          end else begin
            idx <= idx + ONE;
          end
        end

        SCROLL: begin
          // Copy one cell up a row per cycle. Sources in the last row are
          // blanked as they are consumed; they are never read again since
          // later steps only read higher addresses.
          chars[idx] <= chars[scroll_src];
          if (scroll_src >= LAST_ROW) begin
            chars[scroll_src] <= BLANK;
          end
          if (idx == SCROLL_END) begin
            state  <= IDLE;
            cursor <= LAST_ROW;
          end else begin
            idx <= idx + ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;
  localparam int COLS = 32;
  localparam int ROWS = 2;
  localparam int N    = ROWS * COLS;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] chars [N-1:0];
  logic [5:0] cursor;
  logic       busy;

  text_buffer_writer_if bus ();

  text_buffer_writer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .BLANK (BLANK)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (bus),
    .chars  (chars),
    .cursor (cursor),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference screen: plain array plus cursor, updated a whole operation at a time.
  logic [7:0] m [N];
  int         mcur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = BLANK;
    mcur = 0;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        m[r*COLS + c] = m[(r+1)*COLS + c];
    for (int c = 0; c < COLS; c++) m[(ROWS-1)*COLS + c] = BLANK;
    mcur = (ROWS - 1) * COLS;
  endtask

  // Applies one accepted byte; returns how many cycles the block should stay busy.
  task automatic model_apply(input logic [7:0] b, output int busy_exp);
    int row;
    row = mcur / COLS;
    busy_exp = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      m[mcur] = b;
      if (mcur == N - 1) begin
        model_scroll();
        busy_exp = N - COLS;
      end else begin
        mcur++;
      end
    end else if (b == 8'h0A) begin
      if (row < ROWS - 1) mcur = (row + 1) * COLS;
      else begin
        model_scroll();
        busy_exp = N - COLS;
      end
    end else if (b == 8'h0D) begin
      mcur = row * COLS;
    end else if (b == 8'h08) begin
      if (mcur > 0) begin
        mcur--;
        m[mcur] = BLANK;
      end
    end else if (b == 8'h0C) begin
      model_reset();
      busy_exp = N;
    end
  endtask

  task automatic check_screen(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++)
      if (chars[i] !== m[i] && bad < 0) bad = i;
    if (bad < 0) bad = 0;
    chk({tag, " cell"}, chars[bad], m[bad]);
    chk({tag, " cursor"}, cursor, mcur);
  endtask

  // Waits out a busy period (bounded), checking in_ready stays low throughout.
  task automatic wait_busy(input string tag, input int busy_exp);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      chk({tag, " ready low while busy"}, bus.in_ready, 1'b0);
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, " busy cycles"}, cnt, busy_exp);
    chk({tag, " ready after"}, bus.in_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    int be;
    chk({tag, " ready before"}, bus.in_ready, 1'b1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    model_apply(b, be);
    wait_busy(tag, be);
    check_screen(tag);
  endtask

  initial begin
    int be;
    logic [7:0] b;
    int r;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();
    #22;
    check_screen("reset");
    chk("reset busy", busy, 1'b0);
    chk("reset ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "HI"
    send(8'h48, "hi_h");
    send(8'h49, "hi_i");
    chk("hi chars0", chars[0], 8'h48);
    chk("hi chars1", chars[1], 8'h49);
    chk("hi cursor", cursor, 6'd2);

    // Full screen of 'A' forces a scroll on the last byte.
    send(8'h0C, "ff_pre_fill");
    for (int i = 0; i < N; i++) send(8'h41, "fill_a");
    chk("fill cursor", cursor, 6'd32);
    chk("fill row0", chars[31], 8'h41);
    chk("fill row1", chars[32], 8'h20);

    // CR / LF / scroll-by-LF
    send(8'h0C, "ff_crlf");
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), "crlf_pre");
    chk("cursor at 5", cursor, 6'd5);
    send(8'h0D, "cr");
    chk("cr cursor", cursor, 6'd0);
    send(8'h0A, "lf1");
    chk("lf1 cursor", cursor, 6'd32);
    send(8'h51, "q");
    send(8'h52, "r");
    send(8'h53, "s");
    send(8'h0D, "cr2");
    send(8'h0A, "lf_scroll");
    chk("lf scroll cursor", cursor, 6'd32);
    chk("lf scroll row0", chars[0], 8'h51);
    chk("lf scroll row1", chars[32], 8'h20);

    // Backspace
    send(8'h0C, "ff_bs");
    send(8'h41, "bs_a");
    send(8'h42, "bs_b");
    send(8'h08, "bs1");
    chk("bs1 cell", chars[1], 8'h20);
    chk("bs1 cursor", cursor, 6'd1);
    send(8'h08, "bs2");
    send(8'h08, "bs3");
    chk("bs3 cursor", cursor, 6'd0);
    chk("bs3 cell", chars[0], 8'h20);

    // Clear with a byte held valid across the sweep.
    send(8'h58, "x");
    send(8'h59, "y");
    send(8'h5A, "z");
    bus.in_data  = 8'h0C;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    model_apply(8'h0C, be);
    bus.in_data = 8'h4B;
    wait_busy("ff_held", be);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_apply(8'h4B, be);
    check_screen("held byte");
    chk("held chars0", chars[0], 8'h4B);
    chk("held cursor", cursor, 6'd1);

    // Randomized mix of printable and control bytes.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 92) b = 8'h08;
      else if (r < 95) b = 8'h0C;
      else if (r < 97) b = 8'($urandom_range(128, 255));
      else if (r < 98) b = 8'h7F;
      else             b = 8'($urandom_range(0, 7));
      send(b, "rand");
    end

    // Asynchronous reset in the middle of a scroll.
    send(8'h0C, "ff_rst");
    send(8'h0A, "rst_lf");
    for (int i = 0; i < 16; i++) send(8'h5A, "rst_z");
    bus.in_data  = 8'h0A;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rst scroll started", busy, 1'b1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_screen("async reset");
    chk("async reset ready", bus.in_ready, 1'b1);
    chk("async reset busy", busy, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset ready", bus.in_ready, 1'b1);
    chk("post reset cursor", cursor, 6'd0);
    send(8'h4F, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
